uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver with an integrated first-word-fall-through (FWFT) byte FIFO.
//  - Sits between the rx pin and the accelerator command decoder (in_bus side of top).
//  - Replaces the fixed 8N1 receiver: data width, FIFO depth and baud are generics.
//  - Adds glitch rejection, framing/overrun error reporting and optional parity.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock in Hz
//  BAUD        10_000_000   line rate; CLK_PER_BIT = CLK_FREQ/BAUD, must be >= 4
//  DATA_BITS   8            payload bits per frame, range 5..9, sent LSB first
//  FIFO_DEPTH  4            entries; power of two, >= 2
// PORTS
//  clk        in   1                     system clock, rising edge
//  rst_l      in   1                     asynchronous active-low reset
//  rx         in   1                     serial line, idle high, asynchronous to clk
//  rd_en      in   1                     pop head entry; ignored while empty
//  rd_data    out  DATA_BITS             head entry (FWFT); 0 while empty
//  empty      out  1                     FIFO holds no entries
//  full       out  1                     FIFO holds FIFO_DEPTH entries
//  count      out  $clog2(FIFO_DEPTH)+1  current occupancy
//  frame_err  out  1                     1-cycle pulse: stop bit sampled low
//  overrun    out  1                     sticky: good frame dropped because FIFO was full
//  clr_err    in   1                     synchronous clear of overrun
//  parity_err out  1                     1-cycle pulse: parity mismatch (present only with macro)
// BEHAVIOUR
//  - Reset: all outputs 0 except empty=1. Synchroniser flops reset to 1. FSM enters IDLE.
//    FIFO pointers clear. An in-flight frame is discarded.
//  - rx passes through a 2-flop synchroniser; all FSM decisions use the synchronised value.
//  - FSM states: IDLE, START, DATA, PARITY, STOP. One down-counter (tick) and one bit index.
//  - IDLE: a high->low transition on synchronised rx loads tick=CLK_PER_BIT/2-1 and moves to START.
//  - START: at tick==0, rx==0 -> DATA with tick=CLK_PER_BIT-1. rx==1 -> IDLE (glitch; nothing reported).
//  - DATA: at each tick==0, shift rx into bit[idx], reload tick.
//    After bit DATA_BITS-1 -> PARITY if macro defined, else STOP.
//  - PARITY: even parity over data+parity bit, sampled mid-bit; then -> STOP.
//  - STOP: at tick==0, sample rx.
//    - rx==0: frame_err pulse, frame discarded.
//    - parity bad: parity_err pulse, frame discarded.
//    - Otherwise push. If full and rd_en is low, drop the frame and set overrun.
//    - In all cases -> IDLE in the same cycle, so a back-to-back start bit is caught.
//  - Latency: the pushed entry is visible (empty=0, rd_data valid) on the cycle after the
//    stop-bit sample cycle.
//  - FIFO:
//    - Push and pop in the same cycle are both honoured when full (count unchanged,
//      no overrun) and when empty (pop ignored, push lands).
//    - Pointers wrap modulo FIFO_DEPTH.
//  - clr_err coinciding with a new overrun event: set wins.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//  - Frame = start + DATA_BITS + even-parity bit + stop.
//  - parity_err port exists.
//  UART_RX_PARITY_EN undefined:
//  - Frame = start + DATA_BITS + stop.
//  - No PARITY state, no parity_err port.
// STRUCTURE
//  - uart_pkg: rx_state_e enum; function clk_per_bit(CLK_FREQ,BAUD); localparam IDLE_LEVEL=1'b1.
//  - Sub-module sync_fifo #(WIDTH,DEPTH): FWFT storage, count/full/empty. Reusable by the tx path.
//  - This file: synchroniser, FSM, bit counter, error flags.
// TESTING  (CLK_FREQ=100M, BAUD=10M -> 10 clk/bit, DATA_BITS=8, FIFO_DEPTH=4)
//  1. Send 0x10, 8N1 -> empty drops about 100 cycles after start; rd_data=0x10, count=1.
//     rd_en pulse -> empty=1, rd_data=0.
//  2. Send 0x10,0x00,0x03,0x19,0xE0 back-to-back, no reads.
//     -> full after the 4th byte; overrun=1 after the 5th. Pops return 10,00,03,19.
//     clr_err -> overrun=0.
//  3. Hold rd_en high on the exact push cycle while full -> count stays 4, overrun stays 0,
//     the new byte becomes the tail.
//  4. 0xA5 with stop bit driven low -> one frame_err pulse, count unchanged.
//     The following 0x3C is received correctly.
//  5. rx low for 3 cycles only -> START aborts to IDLE, no pulse, no push.
//  6. rst_l asserted after the 4th data bit of 0xFF, then 0x5A sent
//     -> FIFO holds only 0x5A, no errors.
//  7. With UART_RX_PARITY_EN: 0x03 with parity 1 -> parity_err pulse, dropped.
//     With parity 0 -> accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-path types and helpers.
package uart_pkg;

  // Receiver FSM state encoding
  typedef logic [2:0] rx_state_e;
  localparam rx_state_e ST_IDLE   = 3'd0;
  localparam rx_state_e ST_START  = 3'd1;
  localparam rx_state_e ST_DATA   = 3'd2;
  localparam rx_state_e ST_PARITY = 3'd3;
  localparam rx_state_e ST_STOP   = 3'd4;

  // Level of an idle serial line
  localparam logic IDLE_LEVEL = 1'b1;

  // System clocks per serial bit
  function automatic int unsigned clk_per_bit(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through storage with registered head, count, full, empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] head_d;
  logic             push_ok;
  logic             pop_ok;

  // Next pointers, occupancy and the entry that will sit at the head
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count + CW'(push_ok) - CW'(pop_ok);
    if (count_d == '0)
      head_d = '0;
    else if (push_ok && (wr_ptr_q == rd_ptr_d))
      head_d = wr_data;
    else
      head_d = mem[rd_ptr_d];
  end

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers and registered status/head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count    <= count_d;
      empty    <= (count_d == '0);
      full     <= (count_d == CW'(DEPTH));
      rd_data  <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a FWFT byte FIFO, with glitch rejection,
// framing and overrun reporting. Optional even parity: define UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 10_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int unsigned CPB = clk_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned TW  = $clog2(CPB);
  localparam int unsigned IW  = $clog2(DATA_BITS);

  logic                 rx_meta, rx_s, rx_prev;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push_c;
  logic                 frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_d;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
      rx_prev <= IDLE_LEVEL;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM: next state, mid-bit sampling and push/error decisions
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push_c      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = ST_START;
          tick_d  = TW'(CPB / 2 - 1);
        end
      end
      ST_START: begin
        if (tick_q == '0) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            tick_d  = TW'(CPB - 1);
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      ST_DATA: begin
        if (tick_q == '0) begin
          shreg_d[idx_q] = rx_s;
          tick_d         = TW'(CPB - 1);
          if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_q == '0) begin
          par_bad_d = ^{shreg_q, rx_s};
          tick_d    = TW'(CPB - 1);
          state_d   = ST_STOP;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (tick_q == '0) begin
          state_d = ST_IDLE;
          if (!rx_s)
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q)
            parity_err_d = 1'b1;
`endif
          else
            push_c = 1'b1;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM registers and error flags; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      frame_err <= frame_err_d;
      if (push_c && full && !rd_en)
        overrun <= 1'b1;
      else if (clr_err)
        overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      parity_err <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_l),
    .push    (push_c),
    .wr_data (shreg_q),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule
